data_bus_responder: RTL
=======================

// Module: data_bus_responder
// PURPOSE
//  Responder (slave) end of the CPU data memory bus: word-organised scratchpad RAM
//  decoded at a fixed window, answering the multicycle datapath's Dw* bus.
//  Byte-lane writes, registered word reads (1-cycle latency, matching MDR capture).
//  After reset, a clear FSM zeroes the whole array before accepting accesses.
//  Sits beside other bus responders; addresses outside the window are ignored silently.
// PARAMETERS
//  BASE_ADDR    32'h1001_0000  byte address of word 0 (must be 4-byte aligned)
//  DEPTH_WORDS  1024           number of 32-bit words (power of two, >=2)
//  IDX_W        10             index width, = log2(DEPTH_WORDS)
// PORTS
//  iCLK            in   1   system clock, all state on rising edge
//  iRST_N          in   1   asynchronous, active-low reset
//  iDwAddress      in   32  byte address from initiator
//  iDwWriteData    in   32  store data, already lane-aligned by the initiator
//  iDwWriteEnable  in   1   write strobe, sampled every cycle it is high
//  iDwReadEnable   in   1   read strobe
//  iDwByteEnable   in   4   lane mask, bit i -> bits [8i+7:8i]
//  oDwReadData     out  32  registered read word (full word; initiator extracts lanes)
//  oBusy           out  1   1 while clear sweep runs
//  oErr            out  1   one-cycle pulse flagging a rejected in-window access
// BEHAVIOUR
//  Reset (iRST_N=0, async): state=CLEAR, cnt=0, oBusy=1, oDwReadData=0, oErr=0.
//   Reset mid-sweep or mid-access restarts the sweep from index 0; no access completes.
//  Decode: hit = (iDwAddress >= BASE_ADDR) && (iDwAddress < BASE_ADDR+4*DEPTH_WORDS),
//   compare done in 33 bits (no wrap at 2^32). idx = (iDwAddress-BASE_ADDR)>>2, IDX_W bits.
//  FSM CLEAR: each cycle mem[cnt]<=0, cnt<=cnt+1; on the cycle cnt==DEPTH_WORDS-1 is
//   written -> READY; sweep takes exactly DEPTH_WORDS cycles; oBusy falls with READY entry.
//   In CLEAR: in-window RE/WE ignored, write dropped, oDwReadData<=0, oErr pulses.
//  FSM READY (terminal until reset):
//   Write: hit & WE & legal -> for each i with BE[i]: mem[idx] lane i <= WriteData lane i;
//    other lanes unchanged. Takes effect at the same edge.
//   Read: hit & RE -> oDwReadData <= mem[idx] at that edge (visible 1 cycle later).
//    RE & WE same cycle same idx: oDwReadData gets OLD word (read-before-write).
//   RE low, or miss: oDwReadData holds its previous value.
//  Legality (in-window only): iDwAddress[1:0]!=0, or WE with BE==4'b0000 -> illegal;
//   illegal write dropped, illegal read returns 0; oErr=1 the following cycle only.
//  Out-of-window accesses: no write, no read update, no oErr (another responder owns them).
//  oErr is registered; back-to-back illegal accesses give back-to-back pulses.
//  Unknown/unused state encodings recover to CLEAR.
// TESTING
//  1 Release reset, idle bus -> oBusy=1 for exactly DEPTH_WORDS cycles, then 0; read of
//    BASE_ADDR+0x10 returns 32'h0 one cycle after RE.
//  2 Write 32'hDEADBEEF BE=4'hF @BASE+0x8, then BE=4'b0010 data 32'h0000_5500 ->
//    read @BASE+0x8 returns 32'hDEAD55EF.
//  3 Same cycle RE+WE @BASE+0x4 (old 32'h1111_1111, new 32'h2222_2222) -> read data
//    32'h11111111; next read returns 32'h22222222.
//  4 Write @BASE+0x6 or BE=0 @BASE+0x0 -> oErr one-cycle pulse, memory unchanged;
//    access @BASE+4*DEPTH_WORDS and @32'hFFFF_FFFC -> no oErr, oDwReadData holds.
//  5 Write during CLEAR (cycle 5) -> oErr pulse, word still 0 after sweep.
//  6 Assert iRST_N=0 mid-sweep and again after writing 32'hA5A5A5A5 -> oBusy reasserts
//    asynchronously, full re-sweep, location reads 32'h0.

Source files
------------

// File: rtl/data_bus_responder.sv
`default_nettype none
// ============================================================================
// data_bus_responder : scratchpad RAM responder on the Dw* data bus
// Rev 1.0 - initial release
// ============================================================================
module data_bus_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          IDX_W       = 10
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic [31:0] iDwAddress,
  input  logic [31:0] iDwWriteData,
  input  logic        iDwWriteEnable,
  input  logic        iDwReadEnable,
  input  logic [3:0]  iDwByteEnable,
  output logic [31:0] oDwReadData,
  output logic        oBusy,
  output logic        oErr
);

  // Window bounds held in 33 bits so a window touching 2^32 cannot wrap.
  localparam logic [32:0]      c_base  = {1'b0, BASE_ADDR};
  localparam logic [32:0]      c_limit = c_base + 33'(DEPTH_WORDS) * 33'd4;
  localparam logic [IDX_W-1:0] c_last  = IDX_W'(DEPTH_WORDS - 1);

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_READY = 2'd1
  } state_t;

  state_t           r_state;
  logic [IDX_W-1:0] r_cnt;
  logic [31:0]      r_mem [DEPTH_WORDS];

  logic [32:0]      w_addr_ext;
  logic [31:0]      w_off;
  logic [IDX_W-1:0] w_idx;
  logic             w_hit;
  logic             w_access;
  logic             w_illegal;
  logic             w_unused;

  logic             w_mem_we;
  logic [IDX_W-1:0] w_mem_idx;
  logic [3:0]       w_mem_be;
  logic [31:0]      w_mem_wdata;

  assign w_addr_ext = {1'b0, iDwAddress};
  assign w_hit      = (w_addr_ext >= c_base) && (w_addr_ext < c_limit);
  assign w_off      = iDwAddress - BASE_ADDR;
  assign w_idx      = w_off[IDX_W+1:2];
  assign w_access   = w_hit && (iDwReadEnable || iDwWriteEnable);
  assign w_illegal  = (iDwAddress[1:0] != 2'b00) ||
                      (iDwWriteEnable && (iDwByteEnable == 4'b0000));
  assign w_unused   = &{1'b0, w_off[31:IDX_W+2], w_off[1:0]};

  // Single RAM write port shared by the clear sweep and bus stores.
  always_comb begin
    w_mem_we    = 1'b0;
    w_mem_idx   = w_idx;
    w_mem_be    = iDwByteEnable;
    w_mem_wdata = iDwWriteData;
    if (r_state == ST_CLEAR) begin
      w_mem_we    = 1'b1;
      w_mem_idx   = r_cnt;
      w_mem_be    = 4'hF;
      w_mem_wdata = '0;
    end else if ((r_state == ST_READY) && w_access && iDwWriteEnable && !w_illegal) begin
      w_mem_we    = 1'b1;
    end
  end

  always_ff @(posedge iCLK) begin
    if (w_mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_mem_be[i]) begin
          r_mem[w_mem_idx][8*i +: 8] <= w_mem_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state     <= ST_CLEAR;
      r_cnt       <= '0;
      oBusy       <= 1'b1;
      oDwReadData <= '0;
      oErr        <= 1'b0;
    end else begin
      oErr <= 1'b0;
      case (r_state)
        ST_CLEAR: begin
          r_cnt       <= r_cnt + 1'b1;
          oDwReadData <= '0;
          oErr        <= w_access;
          if (r_cnt == c_last) begin
            r_state <= ST_READY;
            oBusy   <= 1'b0;
          end
        end
        ST_READY: begin
          oBusy <= 1'b0;
          if (w_access) begin
            if (w_illegal) begin
              oErr <= 1'b1;
              if (iDwReadEnable) oDwReadData <= '0;
            end else if (iDwReadEnable) begin
              oDwReadData <= r_mem[w_idx];
            end
          end
        end
        default: begin
          r_state     <= ST_CLEAR;
          r_cnt       <= '0;
          oBusy       <= 1'b1;
          oDwReadData <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
